// File: rtl/n64_resp_rx.sv
// n64_resp_rx: decodes the N64 controller's pulse-width reply into an NBITS word, reporting valid/err pulses.
// Define N64_RX_SYNC_EN to add a two-flop din synchronizer (+2 cycles pin-to-decode); no backpressure, results are pulses.
module n64_resp_rx #(
   parameter int NBITS       = 32,
   parameter int SAMPLE_CYC  = 2,
   parameter int TIMEOUT_CYC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             arm,
   output logic [NBITS-1:0] data,
   output logic             valid,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             busy
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(NBITS + 1);
   localparam logic [TW-1:0] TMR_MAX   = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMR_SMP   = TW'(SAMPLE_CYC);
   localparam logic [BW-1:0] BCNT_FULL = BW'(NBITS);

   typedef enum logic [2:0] {
      IDLE, WAIT_FALL, SAMPLE, WAIT_HIGH, STOP_FALL, STOP_HIGH
   } state_t;

   state_t           state, state_nx;
   logic [NBITS-1:0] sr, sr_nx, data_nx;
   logic [BW-1:0]    bcnt, bcnt_nx;
   logic [TW-1:0]    tmr, tmr_nx, tmr_inc;
   logic             valid_nx, err_nx;
   logic [1:0]       code_nx;
   logic             d, d_prev, fall;

`ifdef N64_RX_SYNC_EN
   logic sync1, sync2;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end
   assign d = sync2;
`else
   assign d = din;
`endif

   assign fall    = d_prev & ~d;
   assign tmr_inc = (tmr == TMR_MAX) ? tmr : tmr + TW'(1);
   // Keep busy up through the result pulse so it drops the cycle after valid/err.
   assign busy    = (state != IDLE) | valid | err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         bcnt     <= '0;
         tmr      <= '0;
         data     <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'b00;
         d_prev   <= 1'b1;
      end else begin
         state    <= state_nx;
         sr       <= sr_nx;
         bcnt     <= bcnt_nx;
         tmr      <= tmr_nx;
         data     <= data_nx;
         valid    <= valid_nx;
         err      <= err_nx;
         err_code <= code_nx;
         d_prev   <= d;
      end
   end

   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      bcnt_nx  = bcnt;
      tmr_nx   = tmr_inc;
      data_nx  = data;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      code_nx  = err_code;
      case (state)
         IDLE: begin
            tmr_nx = '0;
            if (arm) begin
               state_nx = WAIT_FALL;
               bcnt_nx  = '0;
               sr_nx    = '0;
            end
         end
         WAIT_FALL: begin
            if (fall) begin
               // The fall-detect cycle itself counts as tmr=0.
               state_nx = SAMPLE;
               tmr_nx   = TW'(1);
            end else if (tmr == TMR_MAX) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               code_nx  = (bcnt == '0) ? 2'b01 : 2'b10;
            end
         end
         SAMPLE: begin
            if (tmr == TMR_SMP) begin
               sr_nx    = {sr[NBITS-2:0], d};
               bcnt_nx  = bcnt + BW'(1);
               state_nx = WAIT_HIGH;
               tmr_nx   = '0;
            end
         end
         WAIT_HIGH: begin
            if (d) begin
               state_nx = (bcnt == BCNT_FULL) ? STOP_FALL : WAIT_FALL;
               tmr_nx   = '0;
            end else if (tmr == TMR_MAX) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               code_nx  = 2'b11;
            end
         end
         STOP_FALL: begin
            if (fall) begin
               state_nx = STOP_HIGH;
               tmr_nx   = '0;
            end else if (tmr == TMR_MAX) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               code_nx  = 2'b10;
            end
         end
         STOP_HIGH: begin
            if (d) begin
               state_nx = IDLE;
               data_nx  = sr;
               valid_nx = 1'b1;
               code_nx  = 2'b00;
            end else if (tmr == TMR_MAX) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               code_nx  = 2'b11;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_n64_resp_rx.sv
// Bench for n64_resp_rx: builds a din/arm/rst timeline, predicts outputs by scanning the line waveform, checks every cycle.
module tb_n64_resp_rx;
   localparam int NB   = 32;
   localparam int TO   = 8;
   localparam int SMP  = 2;
   localparam int MAXT = 8000;
`ifdef N64_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din = 1'b1;
   logic          arm = 1'b0;
   logic [NB-1:0] data;
   logic          valid, err, busy;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   n64_resp_rx #(.NBITS(NB), .SAMPLE_CYC(SMP), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .din(din), .arm(arm), .data(data),
      .valid(valid), .err(err), .err_code(err_code), .busy(busy)
   );

   logic          din_w [MAXT];
   logic          arm_w [MAXT];
   logic          rst_w [MAXT];
   logic          ex_valid [MAXT];
   logic          ex_err [MAXT];
   logic          ex_busy [MAXT];
   logic [NB-1:0] ex_data [MAXT];
   logic [1:0]    ex_code [MAXT];
   logic          h_valid [MAXT];
   logic          h_err [MAXT];
   logic          h_busy [MAXT];
   logic [NB-1:0] h_data [MAXT];
   logic [1:0]    h_code [MAXT];
   int            pos = 0;
   int            checks = 0;
   int            errors = 0;

   task automatic put(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         din_w[pos] = v;
         pos++;
      end
   endtask

   task automatic put_arm();
      arm_w[pos] = 1'b1;
      put(1'b1, 1);
   endtask

   // '1' = 1 low + 3 high, '0' = 3 low + 1 high; ext stretches the high part.
   task automatic put_bit(input logic b, input int ext);
      if (b) begin
         put(1'b0, 1);
         put(1'b1, 3 + ext);
      end else begin
         put(1'b0, 3);
         put(1'b1, 1 + ext);
      end
   endtask

   task automatic put_bits(input logic [NB-1:0] w, input int n, input int maxext);
      for (int i = 0; i < n; i++)
         put_bit(w[NB-1-i], (maxext > 0) ? int'($urandom_range(0, maxext)) : 0);
   endtask

   task automatic put_stop();
      put(1'b0, 1);
      put(1'b1, 3);
   endtask

   // Line level as the decoder sees it: din delayed by the input-stage latency.
   function automatic logic dv(input int t);
      int s;
      s = t - LAT;
      if (s < 0 || s >= MAXT) return 1'b1;
      return din_w[s];
   endfunction

   // Outcome of a frame armed at cycle a: result-pulse cycle, success flag, error code, word.
   task automatic decode(input int a, output int ev, output logic ok,
                         output logic [1:0] code, output logic [NB-1:0] w);
      int   p, f, h, q;
      logic hit;
      p = a + 1; w = '0; ok = 1'b0; code = 2'b00; ev = 0;
      for (int i = 0; i <= NB; i++) begin
         hit = 1'b0; f = 0;
         for (int k = 0; k <= TO && !hit; k++)
            if (dv(p + k - 1) && !dv(p + k)) begin hit = 1'b1; f = p + k; end
         if (!hit) begin
            ev = p + TO + 1;
            code = (i == 0) ? 2'b01 : 2'b10;
            return;
         end
         if (i < NB) begin
            w = {w[NB-2:0], dv(f + SMP)};
            h = f + SMP + 1;
         end else begin
            h = f + 1;
         end
         hit = 1'b0; q = 0;
         for (int k = 0; k <= TO && !hit; k++)
            if (dv(h + k)) begin hit = 1'b1; q = h + k; end
         if (!hit) begin
            ev = h + TO + 1;
            code = 2'b11;
            return;
         end
         if (i == NB) begin
            ev = q + 1;
            ok = 1'b1;
            return;
         end
         p = q + 1;
      end
   endtask

   task automatic build_model();
      int            t, ev, r;
      logic          ok;
      logic [1:0]    code, cc;
      logic [NB-1:0] w, cd;
      cd = '0; cc = 2'b00;
      for (int i = 0; i < MAXT; i++) begin
         ex_valid[i] = 1'b0; ex_err[i] = 1'b0; ex_busy[i] = 1'b0;
         ex_data[i] = '0; ex_code[i] = 2'b00;
      end
      t = 0;
      while (t < pos) begin
         ex_data[t] = cd;
         ex_code[t] = cc;
         if (rst_w[t]) begin
            cd = '0; cc = 2'b00; t++;
            continue;
         end
         if (arm_w[t]) begin
            decode(t, ev, ok, code, w);
            if (ev >= MAXT) ev = MAXT - 1;
            r = -1;
            for (int k = t + 1; k < ev && r < 0; k++) if (rst_w[k]) r = k;
            if (r >= 0) begin
               for (int k = t + 1; k <= r; k++) begin
                  ex_busy[k] = 1'b1; ex_data[k] = cd; ex_code[k] = cc;
               end
               cd = '0; cc = 2'b00; t = r + 1;
               continue;
            end
            for (int k = t + 1; k < ev; k++) begin
               ex_busy[k] = 1'b1; ex_data[k] = cd; ex_code[k] = cc;
            end
            ex_busy[ev] = 1'b1;
            if (ok) begin ex_valid[ev] = 1'b1; cd = w; cc = 2'b00; end
            else begin ex_err[ev] = 1'b1; cc = code; end
            t = ev;
            continue;
         end
         t++;
      end
   endtask

   task automatic cmp(input string nm, input int t, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", nm, t, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] pick(input int sel, input int t, input logic from_dut);
      case (sel)
         0:       return NB'(from_dut ? h_valid[t] : ex_valid[t]);
         1:       return NB'(from_dut ? h_err[t] : ex_err[t]);
         2:       return NB'(from_dut ? h_busy[t] : ex_busy[t]);
         3:       return from_dut ? h_data[t] : ex_data[t];
         default: return NB'(from_dut ? h_code[t] : ex_code[t]);
      endcase
   endfunction

   // Hand-derived expectation applied to both the model and the DUT trace.
   task automatic pin(input string nm, input int sel, input int t, input logic [NB-1:0] exp);
      cmp({"model_", nm}, t, pick(sel, t, 1'b0), exp);
      cmp({"dut_", nm}, t, pick(sel, t, 1'b1), exp);
   endtask

   initial begin
      int a1, a2, a3, a4, a5, a6, a7, rcut;
      for (int i = 0; i < MAXT; i++) begin
         din_w[i] = 1'b1; arm_w[i] = 1'b0; rst_w[i] = 1'b0;
         h_valid[i] = 1'b0; h_err[i] = 1'b0; h_busy[i] = 1'b0; h_data[i] = '0; h_code[i] = 2'b00;
      end
      for (int i = 0; i < 5; i++) rst_w[i] = 1'b1;
      put(1'b1, 10);
      a1 = pos; put_arm(); put_bits(32'h8000_0001, 32, 0); put_stop(); put(1'b1, 12);
      a2 = pos; put_arm(); put(1'b1, 15);
      a3 = pos; put_arm(); put_bits(32'hA5C3_0000, 16, 0); put(1'b1, 25);
      a4 = pos; put_arm(); put(1'b0, 12); put(1'b1, 15);
      a5 = pos; put_arm(); put_bits(32'h1234_5678, 10, 0); rcut = a5 + 38; rst_w[rcut] = 1'b1; put(1'b1, 12);
      a6 = pos; put_arm(); put_bits(32'hDEAD_BEEF, 32, 0); put_stop(); put(1'b1, 10);
      a7 = pos; put_arm(); put_bits(32'h3C5A_0F96, 32, 0); put_stop();
      arm_w[a7 + 20] = 1'b1; arm_w[a7 + 77] = 1'b1;
      put(1'b1, 10);
      for (int f = 0; f < 24; f++) begin
         int            kind, k, a;
         logic [NB-1:0] w;
         kind = int'($urandom_range(0, 8));
         k    = int'($urandom_range(1, 31));
         w    = $urandom();
         put(1'b1, int'($urandom_range(2, 9)));
         a = pos; put_arm();
         case (kind)
            0, 1, 2, 3: begin
               put_bits(w, 32, 3); put_stop();
               if (kind == 1) arm_w[a + 1 + int'($urandom_range(0, 100))] = 1'b1;
            end
            4:       put(1'b1, 14);
            5:       begin put_bits(w, k, 0); put(1'b1, 14); end
            6:       begin put_bits(w, k, 0); put(1'b0, 14); put(1'b1, 3); end
            7:       begin put_bits(w, 32, 0); put(1'b1, 14); end
            default: begin put_bits(w, 32, 0); put(1'b0, 12); put(1'b1, 3); end
         endcase
      end
      put(1'b1, 200);
      build_model();

      for (int t = 0; t < pos; t++) begin
         @(posedge clk);
         #1;
         din = din_w[t];
         arm = arm_w[t];
         rst = rst_w[t];
         @(negedge clk);
         h_valid[t] = valid; h_err[t] = err; h_busy[t] = busy; h_data[t] = data; h_code[t] = err_code;
         if (t >= 1) begin
            cmp("valid", t, NB'(valid), NB'(ex_valid[t]));
            cmp("err", t, NB'(err), NB'(ex_err[t]));
            cmp("busy", t, NB'(busy), NB'(ex_busy[t]));
            cmp("data", t, data, ex_data[t]);
            cmp("err_code", t, NB'(err_code), NB'(ex_code[t]));
         end
      end

      pin("reset_busy", 2, 3, 0);
      pin("reset_data", 3, 3, 0);
      pin("reset_code", 4, 3, 0);
      pin("busy_before_arm", 2, a1, 0);
      pin("busy_after_arm", 2, a1 + 1, 1);
      pin("f1_no_early_valid", 0, a1 + 130 + LAT, 0);
      pin("f1_valid", 0, a1 + 131 + LAT, 1);
      pin("f1_data", 3, a1 + 131 + LAT, 32'h8000_0001);
      pin("f1_no_err", 1, a1 + 131 + LAT, 0);
      pin("f1_busy_in_pulse", 2, a1 + 131 + LAT, 1);
      pin("f1_busy_after", 2, a1 + 132 + LAT, 0);
      pin("noresp_early", 1, a2 + 9, 0);
      pin("noresp_err", 1, a2 + 10, 1);
      pin("noresp_code", 4, a2 + 10, 2'b01);
      pin("noresp_data_kept", 3, a2 + 10, 32'h8000_0001);
      pin("trunc_err", 1, a3 + 74 + LAT, 1);
      pin("trunc_code", 4, a3 + 74 + LAT, 2'b10);
      pin("stuck_err", 1, a4 + 13 + LAT, 1);
      pin("stuck_code", 4, a4 + 13 + LAT, 2'b11);
      pin("rst_busy_before", 2, rcut, 1);
      pin("rst_busy", 2, rcut + 1, 0);
      pin("rst_data", 3, rcut + 1, 0);
      pin("rst_code", 4, rcut + 1, 0);
      pin("dead_valid", 0, a6 + 131 + LAT, 1);
      pin("dead_data", 3, a6 + 131 + LAT, 32'hDEAD_BEEF);
      pin("dead_code", 4, a6 + 131 + LAT, 2'b00);
      pin("rearm_valid", 0, a7 + 131 + LAT, 1);
      pin("rearm_data", 3, a7 + 131 + LAT, 32'h3C5A_0F96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
